adder_pipe: RTL

- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
- Splits a WIDTH-bit operation into STAGES equal carry-ripple chunks. One chunk is resolved per clock, and the carry is registered between stages.
- Uses valid/ready handshakes on both sides, so it can sit between the operand-issue logic and the result/flag writeback with backpressure.
- Produces the sum, unsigned carry, signed overflow and zero flags.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 18 +
 rtl/adder_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The operand and sum vectors stay in the top because their width comes from a module parameter.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Per-stage control record; carry is the carry out of the chunk this stage resolved
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple adder for one pipeline chunk.
module adder_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: one CHUNK-bit slice resolved per stage, carry registered between stages.
// The last stage register is the output register; the whole pipe stalls when the output is held.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic             invert_i_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             carry_out,
  output logic             overflow_flag,
  output logic             zero_flag
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  stage_ctl_t       ctl_in [STAGES];
  stage_ctl_t       ctl_d  [STAGES];
  stage_ctl_t       ctl_q  [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic [WIDTH-1:0] s_d    [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  logic             ovf_q;
  logic             zero_q;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign b_eff    = (invert_i_2 == OP_SUB) ? ~i_2 : i_2;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] slice;
    logic             cout;
    logic [WIDTH-1:0] placed;

    if (k == 0) begin : g_head
      assign ctl_in[k] = '{valid: in_valid, carry: invert_i_2,
                           a_msb: i_1[WIDTH-1], b_msb: b_eff[WIDTH-1]};
      assign a_in[k]   = i_1;
      assign b_in[k]   = b_eff;
      assign s_in[k]   = '0;
    end else begin : g_body
      assign ctl_in[k] = ctl_q[k-1];
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign s_in[k]   = s_q[k-1];
    end

    adder_chunk #(.WIDTH(CHUNK)) u_chunk (
      .a    (a_in[k][k*CHUNK +: CHUNK]),
      .b    (b_in[k][k*CHUNK +: CHUNK]),
      .cin  (ctl_in[k].carry),
      .sum  (slice),
      .cout (cout)
    );

    // Bubbles carry all-zero data, so unresolved sum bits are always zero and can simply be OR-ed.
    assign placed   = WIDTH'(slice) << (k*CHUNK);
    assign s_d[k]   = ctl_in[k].valid ? (s_in[k] | placed) : '0;
    assign ctl_d[k] = ctl_in[k].valid
                      ? '{valid: 1'b1, carry: cout, a_msb: ctl_in[k].a_msb, b_msb: ctl_in[k].b_msb}
                      : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        s_q[k]   <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        s_q[k]   <= s_d[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
      end
      ovf_q  <= ctl_d[LAST].valid & (ctl_d[LAST].a_msb == ctl_d[LAST].b_msb)
                & (s_d[LAST][WIDTH-1] != ctl_d[LAST].a_msb);
      zero_q <= ctl_d[LAST].valid & (s_d[LAST] == '0);
    end
  end

  assign out_valid     = ctl_q[LAST].valid;
  assign o             = s_q[LAST];
  assign carry_out     = ctl_q[LAST].carry;
  assign overflow_flag = ovf_q;
  assign zero_flag     = zero_q;

endmodule
